data_memory_responder: RTL and testbench

- Data-memory slave driven by the microcoded control unit's memory strobes.
- It latches a word address from the shared 16-bit bus when the control unit asserts its address-write strobe.
- It writes bus data into memory, or returns a registered read word onto the bus one cycle after a read strobe.
- It reports protocol violations (access with no valid address, read and write asserted together) through a sticky error flag.

---
 rtl/data_memory_responder.sv | 104 ++++++++++
 tb/tb_data_memory_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_memory_responder.sv
// data_memory_responder: data-memory slave for the microcoded control unit.
// Latches a word address from the shared bus, performs zero-latency writes
// and returns registered read data one cycle after a read strobe. Protocol
// violations set a sticky error flag that only reset clears.
//
// Strobe semantics: there is no ready/backpressure. Each strobe is sampled
// on every rising clk edge and acted on at that edge. An access is accepted
// only if the address was valid BEFORE that edge and exactly one of read or
// write is asserted. An accepted read produces exactly one out_bus_enable
// cycle on the following cycle. Everything else that asserts read or write
// is a violation and is otherwise ignored.
//
// FSM state is fully observable: out_addr_valid is the addr_valid bit and
// out_bus_enable is the read_pending bit of the state encoding.
module data_memory_responder #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_bus,
    input  logic              in_mem_addr_write_en,
    input  logic              in_data_memory_read_enable,
    input  logic              in_data_memory_wr_enable,
    output logic [DATA_W-1:0] out_bus,
    output logic              out_bus_enable,
    output logic [ADDR_W-1:0] out_addr,
    output logic              out_addr_valid,
    output logic              out_error
);

    localparam int DEPTH = 1 << ADDR_W;

    // Encoding is {addr_valid, read_pending}; 2'b01 cannot occur.
    typedef enum logic [1:0] {
        NO_ADDR = 2'b00,
        IDLE    = 2'b10,
        READ    = 2'b11
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   rd_data_q;
    logic                error_q;
    logic                error_nxt;
    logic                addr_valid;
    logic                rd_accept;
    logic                wr_accept;
    logic                violation;

    logic [DATA_W-1:0]   mem [DEPTH];

    // Access qualification, next state and sticky error, all from pre-edge state.
    always_comb begin
        addr_valid = (state != NO_ADDR);
        rd_accept  = addr_valid && in_data_memory_read_enable && !in_data_memory_wr_enable;
        wr_accept  = addr_valid && in_data_memory_wr_enable && !in_data_memory_read_enable;
        violation  = (in_data_memory_read_enable && in_data_memory_wr_enable) ||
                     ((in_data_memory_read_enable || in_data_memory_wr_enable) && !addr_valid);
        error_nxt  = error_q || violation;
        state_nxt  = NO_ADDR;
        case (state)
            NO_ADDR: state_nxt = in_mem_addr_write_en ? IDLE : NO_ADDR;
            IDLE,
            READ:    state_nxt = rd_accept ? READ : IDLE;
            default: state_nxt = NO_ADDR;
        endcase
    end

    // State, address, read capture and error registers; reset drops any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= NO_ADDR;
            addr_q    <= '0;
            rd_data_q <= '0;
            error_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            error_q <= error_nxt;
            if (rd_accept) begin
                rd_data_q <= mem[addr_q];
            end
            // Upper bus bits are dropped: the address wraps by truncation.
            if (in_mem_addr_write_en) begin
                addr_q <= in_bus[ADDR_W-1:0];
            end
        end
    end

    // Memory array write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[addr_q] <= in_bus;
        end
    end

    assign out_bus_enable = (state == READ);
    assign out_bus        = out_bus_enable ? rd_data_q : '0;
    assign out_addr       = addr_q;
    assign out_addr_valid = (state != NO_ADDR);
    assign out_error      = error_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: directed scenarios with literal
// expectations plus a randomized phase, all checked against a transaction
// level model (memory array, address register, sticky error, read queue).
module tb_data_memory_responder;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    // ---------------- clock / reset ----------------
    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic [DATA_W-1:0] in_bus = '0;
    logic              addr_we = 1'b0;
    logic              rd_en = 1'b0;
    logic              wr_en = 1'b0;
    logic [DATA_W-1:0] out_bus;
    logic              out_bus_enable;
    logic [ADDR_W-1:0] out_addr;
    logic              out_addr_valid;
    logic              out_error;

    always #5 clk = ~clk;

    data_memory_responder #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk                        (clk),
        .reset                      (reset),
        .in_bus                     (in_bus),
        .in_mem_addr_write_en       (addr_we),
        .in_data_memory_read_enable (rd_en),
        .in_data_memory_wr_enable   (wr_en),
        .out_bus                    (out_bus),
        .out_bus_enable             (out_bus_enable),
        .out_addr                   (out_addr),
        .out_addr_valid             (out_addr_valid),
        .out_error                  (out_error)
    );

    int checks = 0;
    int errors = 0;
    bit compare_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [DATA_W-1:0] exp_mem [DEPTH];
    logic [ADDR_W-1:0] m_addr = '0;
    logic              m_valid = 1'b0;
    logic              m_err = 1'b0;
    logic [DATA_W-1:0] exp_q[$];

    initial begin
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = '0;
    end

    // Transaction model: accesses use the address held before the edge.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_addr  = '0;
            m_valid = 1'b0;
            m_err   = 1'b0;
            exp_q.delete();
        end else begin
            if ((rd_en || wr_en) && (!m_valid || (rd_en && wr_en))) m_err = 1'b1;
            if (m_valid && rd_en && !wr_en) exp_q.push_back(exp_mem[m_addr]);
            if (m_valid && wr_en && !rd_en) exp_mem[m_addr] = in_bus;
            if (addr_we) begin
                m_addr  = in_bus[ADDR_W-1:0];
                m_valid = 1'b1;
            end
        end
    end

    // ---------------- scoreboard compare ----------------
    logic [DATA_W-1:0] cmp_word;
    logic              cmp_en;
    always @(negedge clk) begin
        if (compare_on) begin
            cmp_en   = (exp_q.size() != 0);
            cmp_word = cmp_en ? exp_q.pop_front() : '0;
            chk("sb_bus_enable", out_bus_enable, cmp_en);
            chk("sb_bus", out_bus, cmp_word);
            chk("sb_addr", out_addr, m_addr);
            chk("sb_addr_valid", out_addr_valid, m_valid);
            chk("sb_error", out_error, m_err);
        end
    end

    // ---------------- driver tasks ----------------
    // Apply strobes for one edge, then return 1 time unit after that edge.
    task automatic step(input logic we, input logic rd, input logic wr, input logic [DATA_W-1:0] bus);
        addr_we = we;
        rd_en   = rd;
        wr_en   = wr;
        in_bus  = bus;
        @(posedge clk);
        #1;
        addr_we = 1'b0;
        rd_en   = 1'b0;
        wr_en   = 1'b0;
    endtask

    task automatic do_reset();
        #2;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic we, rd, wr;
        logic [DATA_W-1:0] bus;

        do_reset();
        compare_on = 1'b1;
        chk("lit_reset_addr", out_addr, 8'h00);
        chk("lit_reset_valid", out_addr_valid, 1'b0);
        chk("lit_reset_en", out_bus_enable, 1'b0);
        chk("lit_reset_bus", out_bus, 16'h0000);
        chk("lit_reset_err", out_error, 1'b0);

        // Read before any address latch.
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("lit_noaddr_err", out_error, 1'b1);
        chk("lit_noaddr_en", out_bus_enable, 1'b0);

        // Reset, then latch 0x12.
        do_reset();
        chk("lit_rst2_err", out_error, 1'b0);
        step(1'b1, 1'b0, 1'b0, 16'h0012);
        chk("lit_latch_addr", out_addr, 8'h12);
        chk("lit_latch_valid", out_addr_valid, 1'b1);
        chk("lit_latch_err", out_error, 1'b0);
        chk("lit_latch_bus", out_bus, 16'h0000);

        // Fill every word so later reads have known contents.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 1'b0, 16'(i));
            step(1'b0, 1'b0, 1'b1, 16'($urandom));
        end

        // Write then read with latency 1.
        step(1'b1, 1'b0, 1'b0, 16'h0012);
        step(1'b0, 1'b0, 1'b1, 16'hBEEF);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("lit_rd_en", out_bus_enable, 1'b1);
        chk("lit_rd_bus", out_bus, 16'hBEEF);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("lit_rd_en_drop", out_bus_enable, 1'b0);
        chk("lit_rd_bus_drop", out_bus, 16'h0000);

        // Truncation and old-address rule.
        step(1'b1, 1'b0, 1'b0, 16'hFF05);
        chk("lit_trunc_addr", out_addr, 8'h05);
        step(1'b0, 1'b0, 1'b1, 16'h5555);
        step(1'b1, 1'b1, 1'b0, 16'h0007);
        chk("lit_old_addr_bus", out_bus, 16'h5555);
        chk("lit_old_addr_en", out_bus_enable, 1'b1);
        chk("lit_new_addr", out_addr, 8'h07);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("lit_old_addr_drop", out_bus_enable, 1'b0);

        // Back-to-back reads.
        step(1'b1, 1'b0, 1'b0, 16'h0001);
        step(1'b0, 1'b0, 1'b1, 16'h000A);
        step(1'b1, 1'b0, 1'b0, 16'h0002);
        step(1'b0, 1'b0, 1'b1, 16'h000B);
        step(1'b1, 1'b0, 1'b0, 16'h0001);
        step(1'b1, 1'b1, 1'b0, 16'h0002);
        chk("lit_b2b_en1", out_bus_enable, 1'b1);
        chk("lit_b2b_bus1", out_bus, 16'h000A);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("lit_b2b_en2", out_bus_enable, 1'b1);
        chk("lit_b2b_bus2", out_bus, 16'h000B);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        chk("lit_b2b_drop", out_bus_enable, 1'b0);

        // Reset mid-read: asserted while out_bus_enable is high.
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("lit_midrd_en_before", out_bus_enable, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        chk("lit_midrd_en", out_bus_enable, 1'b0);
        chk("lit_midrd_bus", out_bus, 16'h0000);
        chk("lit_midrd_valid", out_addr_valid, 1'b0);
        chk("lit_midrd_err", out_error, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0, 16'h0002);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("lit_mem_kept", out_bus, 16'h000B);

        // Read and write together at a valid address.
        do_reset();
        step(1'b1, 1'b0, 1'b0, 16'h0003);
        step(1'b0, 1'b0, 1'b1, 16'h1111);
        chk("lit_rw_err_before", out_error, 1'b0);
        step(1'b0, 1'b1, 1'b1, 16'h2222);
        chk("lit_rw_err", out_error, 1'b1);
        chk("lit_rw_en", out_bus_enable, 1'b0);
        step(1'b0, 1'b1, 1'b0, 16'h0000);
        chk("lit_rw_mem", out_bus, 16'h1111);
        step(1'b0, 1'b0, 1'b0, 16'h0000);

        // Randomized traffic, mostly on low addresses to force reuse.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                we  = ($urandom_range(0, 9) < 3);
                rd  = ($urandom_range(0, 9) < 4);
                wr  = ($urandom_range(0, 9) < 3);
                bus = ($urandom_range(0, 1) == 1) ? {8'($urandom), 8'($urandom_range(0, 15))}
                                                  : 16'($urandom);
                step(we, rd, wr, bus);
            end
        end

        step(1'b0, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
